// File: rtl/cnt_sched_pkg.sv
// Shared state encoding and constants for the counter burst scheduler.
package cnt_sched_pkg;

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] RUN    = 5'b00010;
  localparam logic [4:0] DRAIN1 = 5'b00100;
  localparam logic [4:0] DRAIN2 = 5'b01000;
  localparam logic [4:0] FAULT  = 5'b10000;

  localparam int DRAIN_CYCLES = 2;

  localparam logic PTR_UP = 1'b0;
  localparam logic PTR_DN = 1'b1;

  typedef enum logic [4:0] {
    S_IDLE   = IDLE,
    S_RUN    = RUN,
    S_DRAIN1 = DRAIN1,
    S_DRAIN2 = DRAIN2,
    S_FAULT  = FAULT
  } state_t;

endpackage

// File: rtl/cnt_sched_if.sv
// Requester and counter-side signals of cnt_sched; master is the environment
// (both requesters plus the counter), slave is the scheduler.
interface cnt_sched_if #(
  parameter int COUNTER_WIDTH = 4,
  parameter int LEN_WIDTH     = 3
);
  logic                     req_up;
  logic [LEN_WIDTH-1:0]     len_up;
  logic                     req_dn;
  logic [LEN_WIDTH-1:0]     len_dn;
  logic [COUNTER_WIDTH-1:0] count;
  logic                     ovflw;
  logic                     gnt_up;
  logic                     gnt_dn;
  logic                     rej_up;
  logic                     rej_dn;
  logic                     done;
  logic                     act;
  logic                     up_dwn_n;
  logic                     busy;
  logic                     err;

  modport master (
    output req_up, len_up, req_dn, len_dn, count, ovflw,
    input  gnt_up, gnt_dn, rej_up, rej_dn, done, act, up_dwn_n, busy, err
  );

  modport slave (
    input  req_up, len_up, req_dn, len_dn, count, ovflw,
    output gnt_up, gnt_dn, rej_up, rej_dn, done, act, up_dwn_n, busy, err
  );
endinterface

// File: rtl/cnt_sched_arb.sv
// Two-way round-robin arbiter: picks the up or down requester and proposes
// the pointer value to use after that requester has been served.
module rr_arb2
  import cnt_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] sel,
  output logic       nxt_ptr
);

  // Lone requester wins outright; on contention the pointer decides.
  always_comb begin
    sel = 2'b00;
    case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = (ptr == PTR_DN) ? 2'b10 : 2'b01;
      default: sel = 2'b00;
    endcase
  end

  // Pointer favours whichever requester was not just served.
  always_comb begin
    nxt_ptr = ptr;
    if (sel[0]) begin
      nxt_ptr = PTR_DN;
    end else if (sel[1]) begin
      nxt_ptr = PTR_UP;
    end else begin
      nxt_ptr = ptr;
    end
  end

endmodule

// File: rtl/cnt_sched.sv
// Burst scheduler for the shared up/down counter: round-robin between the up
// and down requesters, range guards on the live count, sticky fault on ovflw.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int LEN_WIDTH     = 3
) (
  input  logic       clk,
  input  logic       rst,
  cnt_sched_if.slave bus
);

  localparam int GW = ((COUNTER_WIDTH > LEN_WIDTH) ? COUNTER_WIDTH : LEN_WIDTH) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

  state_t               state_r, state_s;
  logic [LEN_WIDTH-1:0] rem_r, rem_s;
  logic                 ptr_r, ptr_s;
  logic                 gnt_up_r, gnt_up_s, gnt_dn_r, gnt_dn_s;
  logic                 rej_up_r, rej_up_s, rej_dn_r, rej_dn_s;
  logic                 done_r, done_s, act_r, act_s, dir_r, dir_s;
  logic                 busy_r, busy_s, err_r, err_s;
  logic [1:0]           req_s, sel_s;
  logic                 nxt_ptr_s;
  logic [GW-1:0]        cnt_ext_s, len_up_ext_s, len_dn_ext_s, sum_up_s;
  logic                 up_ok_s, dn_ok_s, cand_ok_s;
  logic [LEN_WIDTH-1:0] cand_len_s;

  // A requester still seeing its reject pulse is not evaluated a second time.
  assign req_s = {bus.req_dn & ~rej_dn_r, bus.req_up & ~rej_up_r};

  rr_arb2 u_arb (
    .req     (req_s),
    .ptr     (ptr_r),
    .sel     (sel_s),
    .nxt_ptr (nxt_ptr_s)
  );

  // Guards are evaluated one bit wider than either operand so nothing wraps.
  assign cnt_ext_s    = GW'(bus.count);
  assign len_up_ext_s = GW'(bus.len_up);
  assign len_dn_ext_s = GW'(bus.len_dn);
  assign sum_up_s     = cnt_ext_s + len_up_ext_s;
  assign up_ok_s      = (sum_up_s[GW-1:COUNTER_WIDTH] == {(GW-COUNTER_WIDTH){1'b0}});
  assign dn_ok_s      = (len_dn_ext_s <= cnt_ext_s);
  assign cand_len_s   = sel_s[1] ? bus.len_dn : bus.len_up;
  assign cand_ok_s    = (sel_s[1] ? dn_ok_s : up_ok_s) && (cand_len_s != LEN_ZERO);

  // Next state, burst bookkeeping and next value of every registered output.
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    ptr_s    = ptr_r;
    dir_s    = dir_r;
    gnt_up_s = 1'b0;
    gnt_dn_s = 1'b0;
    rej_up_s = 1'b0;
    rej_dn_s = 1'b0;
    act_s    = 1'b0;
    done_s   = 1'b0;
    if (bus.ovflw) begin
      state_s = S_FAULT;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (sel_s != 2'b00) begin
            ptr_s = nxt_ptr_s;
            if (cand_ok_s) begin
              gnt_up_s = sel_s[0];
              gnt_dn_s = sel_s[1];
              rem_s    = cand_len_s;
              dir_s    = sel_s[0];
              act_s    = 1'b1;
              state_s  = S_RUN;
            end else begin
              rej_up_s = sel_s[0];
              rej_dn_s = sel_s[1];
            end
          end else begin
            ptr_s = ptr_r;
          end
        end
        S_RUN: begin
          rem_s = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            state_s = S_DRAIN1;
          end else begin
            act_s = 1'b1;
          end
        end
        S_DRAIN1: begin
          state_s = S_DRAIN2;
          done_s  = 1'b1;
        end
        S_DRAIN2: state_s = S_IDLE;
        S_FAULT:  state_s = S_FAULT;
        default:  state_s = S_FAULT;
      endcase
    end
    busy_s = (state_s != S_IDLE);
    err_s  = (state_s == S_FAULT);
  end

  // State and registered outputs; rst clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      rem_r    <= LEN_ZERO;
      ptr_r    <= PTR_UP;
      gnt_up_r <= 1'b0;
      gnt_dn_r <= 1'b0;
      rej_up_r <= 1'b0;
      rej_dn_r <= 1'b0;
      done_r   <= 1'b0;
      act_r    <= 1'b0;
      dir_r    <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      rem_r    <= rem_s;
      ptr_r    <= ptr_s;
      gnt_up_r <= gnt_up_s;
      gnt_dn_r <= gnt_dn_s;
      rej_up_r <= rej_up_s;
      rej_dn_r <= rej_dn_s;
      done_r   <= done_s;
      act_r    <= act_s;
      dir_r    <= dir_s;
      busy_r   <= busy_s;
      err_r    <= err_s;
    end
  end

  assign bus.gnt_up   = gnt_up_r;
  assign bus.gnt_dn   = gnt_dn_r;
  assign bus.rej_up   = rej_up_r;
  assign bus.rej_dn   = rej_dn_r;
  assign bus.done     = done_r;
  assign bus.act      = act_r;
  assign bus.up_dwn_n = dir_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched driving a behavioural 4-bit up/down counter:
// directed scenarios followed by randomized request mixes.
module tb_cnt_sched;
  import cnt_sched_pkg::*;

  localparam int CW   = 4;
  localparam int LW   = 3;
  localparam int CMAX = 15;

  localparam int K_GNT_UP = 0;
  localparam int K_GNT_DN = 1;
  localparam int K_REJ_UP = 2;
  localparam int K_REJ_DN = 3;
  localparam int K_DONE   = 4;

  typedef struct {
    int kind;
    int cyc;
    int len;
    int cnt;
    int dir;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       force_ovf = 1'b0;
  logic       wrap_r;

  ev_t  sb[$];
  int   rd_idx = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   act_cycles = 0;
  int   dir_bad = 0;
  logic cur_dir = 1'b0;
  int   m_count = 0;
  int   m_ptr = 0;

  cnt_sched_if #(.COUNTER_WIDTH(CW), .LEN_WIDTH(LW)) bus ();

  cnt_sched #(.COUNTER_WIDTH(CW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: one step per act cycle, sticky ovflw if a step would wrap.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.count <= 4'd0;
      wrap_r    <= 1'b0;
    end else if (load_en) begin
      bus.count <= load_val;
      wrap_r    <= 1'b0;
    end else if (bus.act) begin
      if (bus.up_dwn_n) begin
        wrap_r    <= wrap_r | (bus.count == 4'd15);
        bus.count <= bus.count + 4'd1;
      end else begin
        wrap_r    <= wrap_r | (bus.count == 4'd0);
        bus.count <= bus.count - 4'd1;
      end
    end
  end

  assign bus.ovflw = force_ovf | wrap_r;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int len, input int cnt, input int dir);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.len  = len;
    e.cnt  = cnt;
    e.dir  = dir;
    sb.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (rd_idx >= sb.size()) begin
      check("unexpected_pulse", kind, -1);
    end else begin
      e = sb[rd_idx];
      rd_idx++;
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.cyc);
      if (kind == K_GNT_UP || kind == K_GNT_DN) begin
        act_cycles = 0;
        dir_bad    = 0;
        cur_dir    = (e.dir != 0);
      end
      if (kind == K_DONE) begin
        check("act_cycles", act_cycles, e.len);
        check("dir_during_act", dir_bad, 0);
        check("count_at_done", int'(bus.count), e.cnt);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        act_cycles = 0;
      end else begin
        if (bus.gnt_up) take(K_GNT_UP);
        if (bus.gnt_dn) take(K_GNT_DN);
        if (bus.rej_up) take(K_REJ_UP);
        if (bus.rej_dn) take(K_REJ_DN);
        if (bus.done)   take(K_DONE);
        if (bus.act) begin
          act_cycles++;
          if (bus.up_dwn_n != cur_dir) dir_bad++;
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'({bus.gnt_up, bus.gnt_dn, bus.rej_up, bus.rej_dn, bus.done,
                      bus.act, bus.up_dwn_n, bus.busy, bus.err}), 0);
  endtask

  task automatic load_count(input int v);
    tick();
    load_en  = 1'b1;
    load_val = 4'(v);
    tick();
    load_en  = 1'b0;
    m_count  = v;
  endtask

  // Requesters release their request on the cycle their pulse is seen.
  task automatic wait_drain(output int busy_seen);
    int drained;
    busy_seen = 0;
    drained   = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.busy) busy_seen = 1;
      if (bus.gnt_up || bus.rej_up) bus.req_up = 1'b0;
      if (bus.gnt_dn || bus.rej_dn) bus.req_dn = 1'b0;
      if (rd_idx == sb.size() && !bus.busy && !bus.req_up && !bus.req_dn) begin
        drained = 1;
        break;
      end
    end
    check("drain_in_time", drained, 1);
    bus.req_up = 1'b0;
    bus.req_dn = 1'b0;
    tick();
  endtask

  // Reference: serve candidates in RR order, each grant costing L+3 cycles and each reject one.
  task automatic issue(input bit do_up, input int lu, input bit do_dn, input int ld);
    int t, first, side, len, any_gnt, bs;
    bit ok;
    t = cyc;
    bus.len_up = LW'(lu);
    bus.len_dn = LW'(ld);
    bus.req_up = do_up;
    bus.req_dn = do_dn;
    any_gnt = 0;
    first = (do_up && do_dn) ? m_ptr : (do_dn ? 1 : 0);
    for (int i = 0; i < 2; i++) begin
      if (i == 0 || (do_up && do_dn)) begin
        side = (i == 0) ? first : 1 - first;
        len  = side ? ld : lu;
        ok   = (len != 0) && (side ? (len <= m_count) : (m_count + len <= CMAX));
        if (ok) begin
          push(side ? K_GNT_DN : K_GNT_UP, t + 1, len, 0, side ? 0 : 1);
          m_count = side ? m_count - len : m_count + len;
          push(K_DONE, t + len + DRAIN_CYCLES, len, m_count, 0);
          t = t + len + DRAIN_CYCLES + 1;
          any_gnt = 1;
        end else begin
          push(side ? K_REJ_DN : K_REJ_UP, t + 1, 0, 0, 0);
          t = t + 1;
        end
        m_ptr = 1 - side;
      end
    end
    wait_drain(bs);
    check("busy_seen", bs, any_gnt);
    check("count_final", int'(bus.count), m_count);
  endtask

  initial begin
    int t, pulses, mode;
    bus.req_up = 1'b0;
    bus.req_dn = 1'b0;
    bus.len_up = 3'd0;
    bus.len_dn = 3'd0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Contention from reset: up first (8->11), then down (11->9).
    load_count(8);
    issue(1'b1, 3, 1'b1, 2);
    // Single up burst from zero.
    load_count(0);
    issue(1'b1, 5, 1'b0, 0);
    // Guards: overflow refused, exact underflow bound accepted.
    load_count(13);
    issue(1'b1, 3, 1'b0, 0);
    load_count(2);
    issue(1'b0, 0, 1'b1, 2);
    check("no_err_after_guards", int'(bus.err), 0);
    // Zero-length request.
    issue(1'b0, 0, 1'b1, 0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) != 0) load_count(int'($urandom_range(0, CMAX)));
      mode = int'($urandom_range(1, 3));
      issue(mode[0], int'($urandom_range(0, 7)), mode[1], int'($urandom_range(0, 7)));
    end

    // Fault injected mid-RUN.
    load_count(0);
    t = cyc;
    bus.len_up = 3'd7;
    bus.req_up = 1'b1;
    push(K_GNT_UP, t + 1, 7, 0, 1);
    tick();
    bus.req_up = 1'b0;
    tick();
    tick();
    force_ovf = 1'b1;
    tick();
    check("fault_act", int'(bus.act), 0);
    check("fault_err", int'(bus.err), 1);
    check("fault_busy", int'(bus.busy), 1);
    force_ovf  = 1'b0;
    bus.len_up = 3'd1;
    bus.len_dn = 3'd1;
    bus.req_up = 1'b1;
    bus.req_dn = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += int'(bus.gnt_up | bus.gnt_dn | bus.rej_up | bus.rej_dn);
    end
    check("fault_no_pulses", pulses, 0);
    check("fault_err_sticky", int'(bus.err), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("fault_reset");
    bus.req_up = 1'b0;
    bus.req_dn = 1'b0;
    tick();
    rst = 1'b0;
    m_count = 0;
    m_ptr = 0;
    tick();

    // Reset in the third RUN cycle of a 7-step burst, then a normal burst.
    load_count(0);
    t = cyc;
    bus.len_up = 3'd7;
    bus.req_up = 1'b1;
    push(K_GNT_UP, t + 1, 7, 0, 1);
    tick();
    bus.req_up = 1'b0;
    tick();
    tick();
    check("mid_act_before_reset", int'(bus.act), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_burst_reset");
    tick();
    rst = 1'b0;
    m_count = 0;
    m_ptr = 0;
    tick();
    issue(1'b1, 2, 1'b0, 0);

    check("scoreboard_drained", rd_idx, sb.size());
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
# cnt_sched

Two-requester scheduler for the shared `COUNTER_WIDTH`-bit up/down counter, which has act, up_dwn_n, count and ovflw ports. It arbitrates round-robin between an "up" requester and a "down" requester, each asking for a burst of `len` steps. It guards every burst against overflow and underflow using the counter's live value, and sequences the counter's act and up_dwn_n inputs. It latches a sticky fault if the counter ever reports ovflw. It sits between the accumulation/decimation logic of the averaging unit and the counter instance.

## Interface
- `COUNTER_WIDTH`, default 4: counter width; must match the counter instance.
- `LEN_WIDTH`, default 3: width of the burst-length fields.
- `clk` in, 1 bit: clock.
- `rst` in, 1 bit: asynchronous, active-high reset. The counter's rst_n is tied to ~rst at integration.
- `req_up` in, 1 bit: up request. Held high until a `gnt_up` or `rej_up` pulse.
- `len_up` in, `LEN_WIDTH` bits: up step count. Stable while `req_up` is high.
- `req_dn` in, 1 bit: down request. Same holding rule as `req_up`.
- `len_dn` in, `LEN_WIDTH` bits: down step count. Same stability rule as `len_up`.
- `count` in, `COUNTER_WIDTH` bits: live counter value.
- `ovflw` in, 1 bit: counter overflow flag.
- `gnt_up` / `gnt_dn` out, 1 bit each: one-cycle pulse, burst accepted.
- `rej_up` / `rej_dn` out, 1 bit each: one-cycle pulse, burst refused (guard fail or len 0).
- `done` out, 1 bit: one-cycle pulse, burst complete and `count` settled.
- `act` out, 1 bit: drives counter act.
- `up_dwn_n` out, 1 bit: drives counter up_dwn_n.
- `busy` out, 1 bit: high in any state other than IDLE.
- `err` out, 1 bit: sticky fault flag.

## Operation
- All outputs are registered.
- On `rst`, every output is 0, the state is IDLE and the RR pointer selects up. This takes effect asynchronously, including mid-burst; `act` drops immediately.
- FSM states are IDLE, RUN, DRAIN1, DRAIN2 and FAULT, one-hot encoded.
- **IDLE**
  - Candidate selection: the only requester if one is active. If both are active, the one the RR pointer selects.
  - Guard for up: `count + len_up <= 2^COUNTER_WIDTH - 1`, computed at `COUNTER_WIDTH+1` bits with no wrap.
  - Guard for down: `len_dn <= count`.
  - Guard pass and len ≠ 0: pulse gnt for the candidate, load the remaining-steps register with len, set `up_dwn_n` (1 = up), assert `act`, go to RUN.
  - Guard fail or len = 0: pulse rej for the candidate and stay in IDLE.
  - After either a grant or a reject, the RR pointer moves to the other requester.
  - A non-selected requester waits; it is never dropped.
- **RUN**
  - `act` is held high and `up_dwn_n` held constant.
  - The remaining-steps register decrements each cycle.
  - When it reaches 1, deassert `act` and go to DRAIN1.
- **DRAIN1 -> DRAIN2**: fixed progression. `done` is high during DRAIN2, then the FSM returns to IDLE.
- **Fault**: `ovflw` high in any state (sampled) sends the FSM to FAULT. FAULT sets `act`=0 and `err`=1, ignores and never grants or rejects requests, and is exited only by `rst`.
- No requests are accepted in RUN, DRAIN1 or DRAIN2. Pending requests wait for IDLE.

## Timing
- Request seen in IDLE at cycle t:
  - gnt pulse in t+1.
  - `act` high in cycles t+1 .. t+L, exactly L cycles.
  - DRAIN1 in t+L+1.
  - DRAIN2 with `done` in t+L+2.
  - IDLE in t+L+3.
- The counter adds exactly L steps.
- `count` is final and stable in t+L+2 (the `done` cycle), so the next guard in IDLE always evaluates a settled value.
- Back-to-back bursts have a minimum spacing of L+3 cycles.
- A reject costs one cycle: rej pulse in t+1, and the next evaluation happens in t+1.
- Guard bound: with the guard satisfied, the counter never reaches its own ovflw check condition. Any ovflw therefore indicates a counter or integration fault.

## Structure
- Package `cnt_sched_pkg` holds the one-hot state localparams (IDLE=5'b00001, RUN, DRAIN1, DRAIN2, FAULT=5'b10000) and the `DRAIN_CYCLES`=2 constant.
- Sub-module `rr_arb2` is the two-way round-robin arbiter. Its inputs are the two requests and the pointer; its outputs are the one-hot select and the next-pointer value. The FSM, guard arithmetic and step counter live in `cnt_sched`.

## Test plan
All scenarios use `COUNTER_WIDTH`=4 and `LEN_WIDTH`=3.
- **Single up burst.** `count`=0; `req_up` with `len_up`=5 -> `gnt_up` at t+1, `act` high 5 cycles, `up_dwn_n`=1, `done` at t+7, `count`=5.
- **Contention.** `count`=8; `req_up`(3) and `req_dn`(2) raised in the same cycle -> up granted first, `count` reaches 11. Then down is granted, `count` reaches 9. The RR pointer ends selecting up.
- **Guards.** `count`=13 with `req_up` `len_up`=3 -> `rej_up`, no `act`, `count` stays 13. `count`=2 with `req_dn` `len_dn`=2 -> grant, `count`=0, no `err`.
- **Zero length.** `len_dn`=0 -> `rej_dn` pulse, FSM stays in IDLE, `busy` stays 0.
- **Fault.** Force `ovflw`=1 mid-RUN -> next cycle `act`=0 and `err`=1. Later requests get no gnt or rej. `rst` clears all outputs.
- **Reset mid-burst.** Assert `rst` in the third RUN cycle of a `len`=7 burst -> `act`, `busy` and `done` are 0 immediately. After release, a new request is granted normally.
